// File: rtl/hidden_layer_pkg.sv
// Shared types, constant weight/bias tables and FSM encoding for the first
// hidden layer. Optional ReLU activation is selected by HIDDEN_RELU_EN.
package hidden_layer_pkg;
  typedef logic signed [4:0]  act_t;
  typedef logic signed [11:0] acc_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_OUT} state_e;

  localparam int N_IN  = 4;
  // Table rows; neurons beyond N_TAB reuse rows modulo N_TAB.
  localparam int N_TAB = 4;

  // Weights: 2 on the diagonal, 0 elsewhere.
  localparam act_t W [N_TAB][N_IN] = '{
    '{act_t'(2), act_t'(0), act_t'(0), act_t'(0)},
    '{act_t'(0), act_t'(2), act_t'(0), act_t'(0)},
    '{act_t'(0), act_t'(0), act_t'(2), act_t'(0)},
    '{act_t'(0), act_t'(0), act_t'(0), act_t'(2)}};
  localparam act_t B [N_TAB] = '{act_t'(1), act_t'(0), act_t'(0), act_t'(-1)};

  function automatic act_t w_of(input int j, input logic [1:0] i);
    logic [1:0] jj;
    jj = 2'(j % N_TAB);
    return W[jj][i];
  endfunction

  function automatic act_t b_of(input int j);
    logic [1:0] jj;
    jj = 2'(j % N_TAB);
    return B[jj];
  endfunction
endpackage

// File: rtl/hidden_neuron_mac.sv
// One hidden neuron: sequential MAC over the latched inputs, then
// bias, arithmetic shift, optional ReLU (HIDDEN_RELU_EN) and saturation.
module hidden_neuron_mac
  import hidden_layer_pkg::*;
#(
  parameter int J     = 0,
  parameter int SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       acc_en,
  input  logic       load,
  input  logic [1:0] idx,
  input  act_t       x,
  output act_t       out
);
  acc_t acc_q, acc_d;
  act_t out_q, out_d;
  act_t w, b;
  logic signed [9:0]  prod;
  logic signed [12:0] sum, v, v_act;
  act_t sat;

  // Accumulate, then bias/shift/activate/saturate the finished sum.
  always_comb begin
    w     = w_of(J, idx);
    b     = b_of(J);
    prod  = $signed({{5{w[4]}}, w}) * $signed({{5{x[4]}}, x});
    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (acc_en) acc_d = acc_q + {{2{prod[9]}}, prod};
    // One guard bit so acc + bias can never wrap.
    sum = $signed({acc_q[11], acc_q}) + $signed({{8{b[4]}}, b});
    v   = sum >>> SHIFT;
`ifdef HIDDEN_RELU_EN
    v_act = (v < 13'sd0) ? 13'sd0 : v;
`else
    v_act = v;
`endif
    if (v_act > 13'sd15)       sat = 5'sd15;
    else if (v_act < -13'sd16) sat = -5'sd16;
    else                       sat = v_act[4:0];
    out_d = load ? sat : out_q;
  end

  // Accumulator and result registers; result holds until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;
endmodule

// File: rtl/hidden_layer_mac.sv
// First hidden layer: latches four activations, steps all neurons through a
// 4-cycle MAC, then publishes results with a one-cycle output_ready pulse.
// Optional ReLU activation is selected by HIDDEN_RELU_EN.
module hidden_layer_mac
  import hidden_layer_pkg::*;
#(
  parameter int NEURONS = 4,
  parameter int SHIFT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              input_ready,
  input  logic signed [4:0] in0,
  input  logic signed [4:0] in1,
  input  logic signed [4:0] in2,
  input  logic signed [4:0] in3,
  output logic signed [4:0] out [NEURONS],
  output logic              output_ready,
  output logic              busy
);
  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  act_t       x_q [N_IN];
  act_t       x_d [N_IN];
  logic       output_ready_q, output_ready_d;
  logic       start, clr, acc_en, load;

  assign start = (state_q == ST_IDLE) && input_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: IDLE -> ACC (4 cycles) -> OUT -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (input_ready) state_d = ST_ACC;
      ST_ACC:  if (idx_q == 2'd3) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs driving the neuron array.
  always_comb begin
    clr    = start;
    acc_en = (state_q == ST_ACC);
    load   = (state_q == ST_OUT);
    busy   = (state_q != ST_IDLE);
  end

  // Input latch, MAC index and ready pulse next-values.
  always_comb begin
    x_d            = x_q;
    idx_d          = idx_q;
    output_ready_d = (state_q == ST_OUT);
    if (start) begin
      x_d[0] = in0;
      x_d[1] = in1;
      x_d[2] = in2;
      x_d[3] = in3;
      idx_d  = 2'd0;
    end else if (state_q == ST_ACC) begin
      idx_d = idx_q + 2'd1;
    end
  end

  // Input latch, MAC index and ready pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
      idx_q          <= '0;
      output_ready_q <= 1'b0;
    end else begin
      x_q            <= x_d;
      idx_q          <= idx_d;
      output_ready_q <= output_ready_d;
    end
  end

  assign output_ready = output_ready_q;

  for (genvar j = 0; j < NEURONS; j++) begin : g_neuron
    hidden_neuron_mac #(.J(j), .SHIFT(SHIFT)) u_neuron (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .acc_en (acc_en),
      .load   (load),
      .idx    (idx_q),
      .x      (x_q[idx_q]),
      .out    (out[j])
    );
  end
endmodule

// File: tb/tb_hidden_layer_mac.sv
// Directed bench for hidden_layer_mac; expectations follow HIDDEN_RELU_EN.
module tb_hidden_layer_mac;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic input_ready = 1'b0;
  logic signed [4:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic signed [4:0] out0 [4];
  logic signed [4:0] out1 [4];
  logic ordy0, ordy1, busy0, busy1;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hidden_layer_mac #(.NEURONS(4), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .input_ready(input_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out(out0), .output_ready(ordy0), .busy(busy0));

  hidden_layer_mac #(.NEURONS(4), .SHIFT(1)) dut1 (
    .clk(clk), .rst(rst), .input_ready(input_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out(out1), .output_ready(ordy1), .busy(busy1));

  // Present one vector for one cycle; lat = cycles from sampling edge to
  // output_ready seen (or -1 on timeout).
  task automatic drive_and_wait(input int a, input int b, input int c, input int d,
                                output int lat);
    @(negedge clk);
    in0 = a[4:0]; in1 = b[4:0]; in2 = c[4:0]; in3 = d[4:0];
    input_ready = 1'b1;
    @(negedge clk);
    input_ready = 1'b0;
    lat = 0;
    while (!ordy0 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (!ordy0) lat = -1;
  endtask

  task automatic test_reset();
    int lat;
    int exp_o [4];
    drive_and_wait(3, -2, 7, 15, lat);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      exp_o[j] = 0;
      if (out0[j] !== 5'(exp_o[j])) begin
        $display("FAIL reset out[%0d] got %0d want %0d", j, out0[j], exp_o[j]); n_fail++;
      end
      n_tests++;
    end
    if (ordy0 !== 1'b0 || busy0 !== 1'b0) begin
      $display("FAIL reset flags got rdy=%b busy=%b want 0 0", ordy0, busy0); n_fail++;
    end
    n_tests++;
    #1 rst = 1'b0;
  endtask

  task automatic test_basic(input int a, input int b, input int c, input int d,
                            input int e0, input int e1, input int e2, input int e3,
                            input string nm);
    int lat;
    int exp_o [4];
    exp_o = '{e0, e1, e2, e3};
    drive_and_wait(a, b, c, d, lat);
    if (lat !== 5) begin
      $display("FAIL %s latency got %0d want 5", nm, lat); n_fail++;
    end
    n_tests++;
    for (int j = 0; j < 4; j++) begin
      if (out0[j] !== 5'(exp_o[j])) begin
        $display("FAIL %s out[%0d] got %0d want %0d", nm, j, out0[j], exp_o[j]); n_fail++;
      end
      n_tests++;
    end
    @(negedge clk);
    if (ordy0 !== 1'b0 || out0[0] !== 5'(exp_o[0])) begin
      $display("FAIL %s hold got rdy=%b out0=%0d want 0 %0d", nm, ordy0, out0[0], exp_o[0]);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_back_to_back();
    int ex [2][4];
    int busy_cnt, rdy_cnt;
    logic [11:0] rdy_at;
`ifdef HIDDEN_RELU_EN
    ex = '{'{3, 0, 6, 0}, '{15, 0, 0, 7}};
`else
    ex = '{'{3, -2, 6, -5}, '{15, -14, -6, 7}};
`endif
    busy_cnt = 0; rdy_cnt = 0; rdy_at = '0;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      int a, b, c, d;
      a = k + 1; b = -(k + 1); c = 3 - k; d = k - 2;
      in0 = a[4:0]; in1 = b[4:0]; in2 = c[4:0]; in3 = d[4:0];
      input_ready = 1'b1;
      @(negedge clk);
      if (busy0) busy_cnt++;
      if (ordy0) begin
        rdy_cnt++;
        rdy_at[k] = 1'b1;
        for (int j = 0; j < 4; j++) begin
          if (out0[j] !== 5'(ex[k / 6][j])) begin
            $display("FAIL b2b k=%0d out[%0d] got %0d want %0d", k, j, out0[j], ex[k / 6][j]);
            n_fail++;
          end
          n_tests++;
        end
      end
    end
    input_ready = 1'b0;
    if (rdy_at !== 12'b1000_0010_0000 || rdy_cnt !== 2) begin
      $display("FAIL b2b ready pattern got %b want 100000100000", rdy_at); n_fail++;
    end
    n_tests++;
    if (busy_cnt !== 10) begin
      $display("FAIL b2b busy cycles got %0d want 10", busy_cnt); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    in0 = 5'sd5; in1 = 5'sd5; in2 = 5'sd5; in3 = 5'sd5;
    input_ready = 1'b1;
    @(negedge clk);
    input_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ordy0) seen++;
    end
    if (seen !== 0 || busy0 !== 1'b0) begin
      $display("FAIL abort ready pulses got %0d busy=%b want 0 0", seen, busy0); n_fail++;
    end
    n_tests++;
    for (int j = 0; j < 4; j++) begin
      if (out0[j] !== 5'sd0) begin
        $display("FAIL abort out[%0d] got %0d want 0", j, out0[j]); n_fail++;
      end
      n_tests++;
    end
  endtask

  task automatic test_shift();
    int lat;
    int exp_o [4];
    exp_o = '{15, 15, 15, 14};
    drive_and_wait(15, 15, 15, 15, lat);
    if (lat !== 5 || ordy1 !== 1'b1) begin
      $display("FAIL shift latency got %0d rdy1=%b want 5 1", lat, ordy1); n_fail++;
    end
    n_tests++;
    for (int j = 0; j < 4; j++) begin
      if (out1[j] !== 5'(exp_o[j])) begin
        $display("FAIL shift out[%0d] got %0d want %0d", j, out1[j], exp_o[j]); n_fail++;
      end
      n_tests++;
    end
  endtask

  initial begin
    test_reset();
`ifdef HIDDEN_RELU_EN
    test_basic(3, -2, 7, 15, 7, 0, 14, 15, "basic");
    test_basic(-16, -16, -16, -16, 0, 0, 0, 0, "neg_sat");
`else
    test_basic(3, -2, 7, 15, 7, -4, 14, 15, "basic");
    // n0: 2*-16 + 1 = -31 saturates to -16
    test_basic(-16, -16, -16, -16, -16, -16, -16, -16, "neg_sat");
`endif
    test_back_to_back();
    test_abort();
`ifdef HIDDEN_RELU_EN
    test_basic(3, -2, 7, 15, 7, 0, 14, 15, "after_abort");
`else
    test_basic(3, -2, 7, 15, 7, -4, 14, 15, "after_abort");
`endif
    test_shift();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
